audio_i2s_tx: RTL and testbench
===============================

// Module: audio_i2s_tx
// PURPOSE
// - Downstream of the radio core: takes the 16-bit signed demodulated audio (one sample per en32k strobe) and
//   serialises it as a standard I2S stream (bclk/lrclk/sdata, master mode) for an external audio DAC.
// - Mono source: the same sample goes out in both left and right slots. Frames are locked to en32k; there is no FIFO.
// PARAMETERS
// - HALF_BCLK  58  clk cycles per bclk half-period; 128*HALF_BCLK must not exceed the clk cycles per en32k period
// - WIDTH      16  audio sample width (bits); must be <= SLOT_BITS-1
// PORTS
// - clk      in   1      system clock (single clock domain)
// - reset    in   1      synchronous, active-high reset
// - en32k    in   1      one-clk audio sample strobe; `in` is valid in this cycle
// - in       in   WIDTH  signed audio sample (two's complement)
// - mute     in   1      if high when a sample is captured, zero is stored instead
// - bclk     out  1      I2S bit clock, registered
// - lrclk    out  1      I2S word select (0 = left, 1 = right), registered
// - sdata    out  1      I2S serial data, MSB first, registered
// - busy     out  1      high while a frame is being shifted
// - overrun  out  1      one-clk pulse when a sample arrives while one is already pending
// BEHAVIOUR
// - Reset: bclk=0, lrclk=1, sdata=0, busy=0, overrun=0. State is IDLE. Pending is cleared. Bit and half counters are zeroed.
// - Capture: on en32k, (mute ? 0 : in) is registered. In IDLE, a FRAME starts on the next cycle (t+1).
// - FRAME: 64 bits, bit index b=0..63. Each bit is HALF_BCLK cycles with bclk=0, then HALF_BCLK cycles with bclk=1.
//   - lrclk, sdata and bclk falling edges all update together at the start of each bit.
//   - lrclk = (b >= 32).
//   - Slot bit s = b mod 32. sdata = sample[WIDTH-s] for 1 <= s <= WIDTH, else 0 (one-bit I2S delay, zero padding).
//   - Frame length is exactly 128*HALF_BCLK cycles. The first MSB appears on sdata at t+1+2*HALF_BCLK.
// - End of frame: after the last high half of b=63, bclk=0 and lrclk stays 1.
//   - If a sample is pending, the next FRAME starts in the very next cycle (no idle gap) and pending is cleared.
//   - Otherwise go to IDLE: busy=0, sdata=0.
// - busy = 1 for every FRAME cycle, including the first. The shift register/sample is frozen for the whole frame.
// - en32k during FRAME: the sample goes to a 1-entry pending register.
//   - If pending is already full, the newer sample overwrites it and overrun pulses for 1 cycle.
//   - The frame in progress is never disturbed.
// - en32k coincident with the final cycle of a frame: treated as pending. It starts the next frame with no gap.
// - Reset mid-frame: abort immediately to the reset values. The partial frame is discarded and pending is cleared.
// - FSM: IDLE -(en32k)-> FRAME; FRAME -(end & pending)-> FRAME; FRAME -(end & !pending)-> IDLE.
// STRUCTURE
// - Shared package audio_pkg:
//   - localparam SLOT_BITS=32, FRAME_BITS=64
//   - typedef enum logic {IDLE, FRAME} i2s_state_t
//   - typedef logic signed [15:0] audio_sample_t
// - One sub-module, i2s_bclk_divider: a HALF_BCLK counter with sync clear at frame start.
//   - Outputs a half-period tick and a phase bit.
//   - The top level holds the FSM, bit counter, sample/pending registers and output flops.
// TESTING
// - Reset then no en32k for 20000 cycles -> bclk=0, lrclk=1, sdata=0, busy=0 throughout.
// - en32k with in=16'h8001, mute=0 -> left slot sdata bits s1..s16 = 1,0...0,1 and s0,s17..31 = 0.
//   Right slot is identical. MSB at t+1+116. busy for 7424 cycles.
// - mute=1 at capture with in=16'h7FFF -> all 64 sdata bits are 0, bclk/lrclk timing unchanged.
// - en32k every 7500 cycles with in=16'h1234 then 16'hFEDC -> two frames, each starting 1 cycle after its strobe.
//   Decoded words are 0x1234 and 0xFEDC. No overrun.
// - Strobes at 0, 100 and 200 (in=1,2,3) -> frame1 carries 1. Strobe 200 overwrites 2, with an overrun pulse.
//   Frame2 starts right after frame1 ends (no gap) and carries 3.
// - Assert reset at frame cycle 3000 with a sample pending -> next cycle is at reset values.
//   No frame follows until a new en32k arrives.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S audio transmitter.
//   SLOT_BITS      bits per I2S channel slot
//   FRAME_BITS     bits per stereo frame (left + right slot)
//   i2s_state_t    transmitter FSM state
//   audio_sample_t 16-bit signed demodulated audio sample
package audio_pkg;

  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;

  typedef enum logic {
    IDLE,
    FRAME
  } i2s_state_t;

  typedef logic signed [15:0] audio_sample_t;

endpackage

// File: rtl/i2s_bclk_divider.sv
// Half-period timer for the I2S bit clock.
//   clk, reset  system clock, synchronous active-high reset
//   clear_i     restart the timer at the beginning of a half period, phase 0
//   run_i       advance the timer (held while the transmitter is idle)
//   tick_o      high during the last clk cycle of a bclk half period
//   phase_o     current bclk half: 0 = low half, 1 = high half
module i2s_bclk_divider #(
  parameter int unsigned HALF_BCLK = 58
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic run_i,
  output logic tick_o,
  output logic phase_o
);

  localparam int unsigned CNT_W = (HALF_BCLK > 1) ? $clog2(HALF_BCLK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BCLK - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             tick_q;

  // Count clk cycles within a half period; flip phase on wrap.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (run_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Tick is registered from the next count so it lines up with cnt_q == CNT_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      tick_q  <= (CNT_LAST == '0);
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      tick_q  <= (cnt_d == CNT_LAST);
    end
  end

  assign tick_o  = tick_q;
  assign phase_o = phase_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono-to-stereo I2S master transmitter for the demodulated audio stream.
// Each en32k sample is sent in both the left and right slot of a 64-bit frame.
//   clk, reset  system clock, synchronous active-high reset
//   en32k       one-cycle sample strobe, qualifies in
//   in          signed audio sample
//   mute        store zero instead of in when capturing
//   bclk        I2S bit clock (registered)
//   lrclk       I2S word select, 0 = left, 1 = right (registered)
//   sdata       I2S serial data, MSB first, one-bit delayed (registered)
//   busy        high during every frame cycle
//   overrun     one-cycle pulse when a pending sample is overwritten
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned HALF_BCLK = 58,
  parameter int unsigned WIDTH     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en32k,
  input  logic [WIDTH-1:0] in,
  input  logic             mute,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned BIT_W  = $clog2(FRAME_BITS);
  localparam int unsigned SLOT_W = $clog2(SLOT_BITS);
  localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  i2s_state_t       state_q, state_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic             tick;
  logic             phase;
  logic             start_c;
  logic             half_end_c;
  logic             bit_end_c;
  logic             frame_end_c;
  logic [WIDTH-1:0] capture_c;

  // Slot bit s carries sample[WIDTH-s] for 1..WIDTH; slot bit 0 is the I2S delay bit.
  function automatic logic slot_bit(input logic [WIDTH-1:0] smp, input logic [SLOT_W-1:0] s);
    logic [SLOT_W-1:0] off;
    off = SLOT_W'(WIDTH) - s;
    if ((s != '0) && (s <= SLOT_W'(WIDTH))) begin
      return smp[off[IDX_W-1:0]];
    end
    return 1'b0;
  endfunction

  i2s_bclk_divider #(
    .HALF_BCLK (HALF_BCLK)
  ) u_bclk_div (
    .clk     (clk),
    .reset   (reset),
    .clear_i (start_c),
    .run_i   (state_q == FRAME),
    .tick_o  (tick),
    .phase_o (phase)
  );

  assign capture_c   = mute ? '0 : in;
  assign half_end_c  = (state_q == FRAME) && tick;
  assign bit_end_c   = half_end_c && phase;
  assign frame_end_c = bit_end_c && (bit_q == LAST_BIT);

  // Next-state, sample/pending bookkeeping and next output values.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    sample_d   = sample_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    overrun_d  = 1'b0;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    busy_d     = busy_q;
    start_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en32k) begin
          start_c  = 1'b1;
          sample_d = capture_c;
          state_d  = FRAME;
        end
      end
      FRAME: begin
        if (frame_end_c) begin
          // A strobe on the last cycle wins over (and overwrites) any pending sample.
          if (en32k) begin
            start_c   = 1'b1;
            sample_d  = capture_c;
            overrun_d = pend_vld_q;
          end else if (pend_vld_q) begin
            start_c  = 1'b1;
            sample_d = pend_q;
          end else begin
            state_d = IDLE;
          end
          pend_vld_d = 1'b0;
        end else begin
          if (bit_end_c) begin
            bit_d = bit_q + BIT_W'(1);
          end
          if (en32k) begin
            pend_d     = capture_c;
            pend_vld_d = 1'b1;
            overrun_d  = pend_vld_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_c) begin
      state_d = FRAME;
      bit_d   = '0;
      bclk_d  = 1'b0;
      lrclk_d = 1'b0;
      sdata_d = 1'b0;
      busy_d  = 1'b1;
    end else if (state_d == IDLE) begin
      bclk_d  = 1'b0;
      lrclk_d = 1'b1;
      sdata_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      // Outputs reflect the bit/phase of the coming cycle so bclk, lrclk and sdata move together.
      bclk_d  = phase ^ half_end_c;
      lrclk_d = (bit_d >= BIT_W'(SLOT_BITS));
      sdata_d = slot_bit(sample_q, bit_d[SLOT_W-1:0]);
      busy_d  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      sample_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      sample_q   <= sample_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bclk    = bclk_q;
  assign lrclk   = lrclk_q;
  assign sdata   = sdata_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx: stimulus pushes expected frames,
// a monitor decodes the I2S stream and compares each completed frame.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  localparam int unsigned HALF      = 58;
  localparam int          FRAME_CYC = 128 * HALF;

  logic          clk = 1'b0;
  logic          reset;
  logic          en32k;
  logic          mute;
  audio_sample_t in_s;
  logic          bclk, lrclk, sdata, busy, overrun;

  typedef struct {
    logic [15:0] word;
    int          start;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ovr_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  audio_i2s_tx #(
    .HALF_BCLK (HALF),
    .WIDTH     (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en32k   (en32k),
    .in      (in_s),
    .mute    (mute),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .sdata   (sdata),
    .busy    (busy),
    .overrun (overrun)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic bits [64];
  logic lrs  [64];
  int   nb = 0;
  int   fstart = 0;
  bit   in_frame = 0;
  logic prev_lr = 1'b1;
  logic prev_bclk = 1'b0;

  task automatic check_frame();
    exp_t        e;
    logic [15:0] left, right;
    int          pad_bad, lr_bad, s;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: frame started at cycle %0d but none was expected", fstart);
      return;
    end
    e = exp_q.pop_front();
    pad_bad = 0;
    lr_bad  = 0;
    for (int i = 0; i < 16; i++) begin
      left[15-i]  = bits[1+i];
      right[15-i] = bits[33+i];
    end
    for (int b = 0; b < 64; b++) begin
      s = b % 32;
      if ((s == 0 || s > 16) && bits[b]) pad_bad++;
      if (lrs[b] != (b >= 32)) lr_bad++;
    end
    chk("frame_start", fstart, e.start);
    chk("left_word", left, e.word);
    chk("right_word", right, e.word);
    chk("pad_bits", pad_bad, 0);
    chk("lrclk_pattern", lr_bad, 0);
  endtask

  always @(negedge clk) begin
    if (in_frame && !busy) in_frame = 0;
    if (prev_lr && !lrclk && busy) begin
      in_frame = 1;
      nb       = 0;
      fstart   = cyc;
    end else if (in_frame && !prev_bclk && bclk) begin
      bits[nb] = sdata;
      lrs[nb]  = lrclk;
      nb++;
      if (nb == 64) begin
        in_frame = 0;
        check_frame();
      end
    end
    if (overrun) ovr_cnt++;
    prev_lr   = lrclk;
    prev_bclk = bclk;
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic strobe(input logic [15:0] v, input logic m, input bit push, output int t);
    exp_t e;
    en32k = 1'b1;
    in_s  = v;
    mute  = m;
    t     = cyc;
    if (push) begin
      e.word  = m ? 16'h0000 : v;
      e.start = t + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    en32k = 1'b0;
    mute  = 1'b0;
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 20000 && cyc < c; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      if (!busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk(name, ok, 1);
  endtask

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, bad, busy_cnt, first_busy, ov0;
    exp_t e;
    reset = 1'b1;
    en32k = 1'b0;
    mute  = 1'b0;
    in_s  = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {bclk, lrclk, sdata, busy, overrun}, 5'b01000);
    reset = 1'b0;

    // Long idle: outputs must stay at their rest values.
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      if ({bclk, lrclk, sdata, busy, overrun} != 5'b01000) bad++;
      @(negedge clk);
    end
    chk("idle_rest_values", bad, 0);

    // 0x8001: MSB timing and busy length.
    strobe(16'h8001, 1'b0, 1'b1, t0);
    busy_cnt   = 0;
    first_busy = -1;
    for (int i = 0; i < FRAME_CYC + 100; i++) begin
      if (cyc == t0 + 1 + 2 * HALF - 1) chk("pre_msb_sdata", sdata, 0);
      if (cyc == t0 + 1 + 2 * HALF)     chk("msb_sdata", sdata, 1);
      if (busy) begin
        if (first_busy < 0) first_busy = cyc;
        busy_cnt++;
      end else if (first_busy >= 0) begin
        break;
      end
      @(negedge clk);
    end
    chk("busy_first_cycle", first_busy, t0 + 1);
    chk("busy_length", busy_cnt, FRAME_CYC);
    wait_idle("drain_8001");

    // Muted capture of 0x7FFF.
    strobe(16'h7FFF, 1'b1, 1'b1, t0);
    wait_idle("drain_mute");

    // Two strobes 7500 cycles apart, no overrun.
    ov0 = ovr_cnt;
    strobe(16'h1234, 1'b0, 1'b1, t1);
    wait_until(t1 + 7500);
    strobe(16'hFEDC, 1'b0, 1'b1, t2);
    wait_idle("drain_two");
    chk("no_overrun", ovr_cnt - ov0, 0);

    // Strobes at 0/100/200: 2 is overwritten by 3, back-to-back frames.
    ov0 = ovr_cnt;
    strobe(16'h0001, 1'b0, 1'b1, t0);
    wait_until(t0 + 100);
    strobe(16'h0002, 1'b0, 1'b0, t1);
    wait_until(t0 + 200);
    strobe(16'h0003, 1'b0, 1'b0, t2);
    e.word  = 16'h0003;
    e.start = t0 + 1 + FRAME_CYC;
    exp_q.push_back(e);
    wait_idle("drain_overrun");
    chk("overrun_pulses", ovr_cnt - ov0, 1);

    // Reset mid-frame with a pending sample.
    strobe(16'h0005, 1'b0, 1'b0, t0);
    wait_until(t0 + 100);
    strobe(16'h0006, 1'b0, 1'b0, t1);
    wait_until(t0 + 3000);
    reset = 1'b1;
    @(negedge clk);
    chk("midframe_reset", {bclk, lrclk, sdata, busy, overrun}, 5'b01000);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 7600; i++) begin
      if (busy) bad++;
      @(negedge clk);
    end
    chk("no_frame_after_reset", bad, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
